// File: rtl/multi_counter_if.sv
// Request/status bundle for the multi_counter bank.
// Per-channel fields are packed side by side; channel i is at [i*WIDTH +: WIDTH].
interface multi_counter_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0]       inc;
  logic [NUM_CH-1:0]       dec;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] load_val;
  logic [NUM_CH*WIDTH-1:0] limit;
  logic [NUM_CH-1:0]       sat_mode;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       unf;
  logic [NUM_CH-1:0]       at_max;
  logic [NUM_CH-1:0]       at_zero;
  logic [NUM_CH-1:0]       ovf_sticky;
  logic [NUM_CH-1:0]       unf_sticky;

  modport master (
    output inc, dec, clr, load, load_val, limit, sat_mode,
    input  count, ovf, unf, at_max, at_zero, ovf_sticky, unf_sticky
  );

  modport slave (
    input  inc, dec, clr, load, load_val, limit, sat_mode,
    output count, ovf, unf, at_max, at_zero, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/multi_counter.sv
// Bank of NUM_CH independent up/down counters with a runtime terminal count,
// wrap or saturate behaviour, load/clear, overflow/underflow strobes and
// sticky event flags. With CASCADE=1 each channel's overflow also counts up
// the next channel, so neighbouring channels form one wide counter.
module multi_counter #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int CASCADE = 0
) (
  input logic           clk,
  input logic           rst,
  multi_counter_if.slave bus
);

  logic [NUM_CH*WIDTH-1:0] count_q;
  logic [NUM_CH*WIDTH-1:0] count_d;
  logic [NUM_CH-1:0]       ovf_c;
  logic [NUM_CH-1:0]       unf_c;
  logic [NUM_CH-1:0]       at_max_c;
  logic [NUM_CH-1:0]       at_zero_c;
  logic [NUM_CH-1:0]       inc_eff;
  logic [NUM_CH-1:0]       ovf_sticky_q;
  logic [NUM_CH-1:0]       unf_sticky_q;

  // Next-count and strobe logic; the overflow of each channel ripples into the next when cascading.
  always_comb begin
    logic             carry;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] dm1;
    carry     = 1'b0;
    cnt       = '0;
    lim       = '0;
    lv        = '0;
    nxt       = '0;
    dm1       = '0;
    count_d   = '0;
    ovf_c     = '0;
    unf_c     = '0;
    at_max_c  = '0;
    at_zero_c = '0;
    inc_eff   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt          = count_q[i*WIDTH +: WIDTH];
      lim          = bus.limit[i*WIDTH +: WIDTH];
      lv           = bus.load_val[i*WIDTH +: WIDTH];
      dm1          = cnt - 1'b1;
      inc_eff[i]   = bus.inc[i] | ((CASCADE != 0) ? carry : 1'b0);
      at_max_c[i]  = (cnt >= lim);
      at_zero_c[i] = (cnt == '0);
      nxt          = cnt;
      if (bus.clr[i]) begin
        nxt = '0;
      end else if (bus.load[i]) begin
        nxt = (lv > lim) ? lim : lv;
      end else if (inc_eff[i] && !bus.dec[i]) begin
        if (cnt >= lim) begin
          ovf_c[i] = 1'b1;
          nxt      = bus.sat_mode[i] ? lim : '0;
        end else begin
          nxt = cnt + 1'b1;
        end
      end else if (bus.dec[i] && !inc_eff[i]) begin
        if (cnt == '0) begin
          unf_c[i] = 1'b1;
          nxt      = bus.sat_mode[i] ? '0 : lim;
        end else begin
          nxt = (bus.sat_mode[i] && (dm1 > lim)) ? lim : dm1;
        end
      end
      count_d[i*WIDTH +: WIDTH] = nxt;
      carry = ovf_c[i];
    end
  end

  // Count registers and sticky flags; a clear beats a same-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      ovf_sticky_q <= '0;
      unf_sticky_q <= '0;
    end else begin
      count_q      <= count_d;
      ovf_sticky_q <= (ovf_sticky_q | ovf_c) & ~bus.clr;
      unf_sticky_q <= (unf_sticky_q | unf_c) & ~bus.clr;
    end
  end

  assign bus.count      = count_q;
  assign bus.ovf        = ovf_c;
  assign bus.unf        = unf_c;
  assign bus.at_max     = at_max_c;
  assign bus.at_zero    = at_zero_c;
  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: one independent bank and one cascaded
// bank share the same stimulus and are compared against an integer model.
module tb_multi_counter;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk;
  logic rst;

  logic [NCH-1:0]   s_inc;
  logic [NCH-1:0]   s_dec;
  logic [NCH-1:0]   s_clr;
  logic [NCH-1:0]   s_load;
  logic [NCH-1:0]   s_sat;
  logic [NCH*W-1:0] s_lv;
  logic [NCH*W-1:0] s_lim;

  int checkCount;
  int passCount;

  int refCnt  [2][NCH];
  bit refOs   [2][NCH];
  bit refUs   [2][NCH];
  bit expOvf  [2][NCH];
  bit expUnf  [2][NCH];
  int expNext [2][NCH];

  multi_counter_if #(.NUM_CH(NCH), .WIDTH(W)) if0 ();
  multi_counter_if #(.NUM_CH(NCH), .WIDTH(W)) if1 ();

  multi_counter #(.NUM_CH(NCH), .WIDTH(W), .CASCADE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  multi_counter #(.NUM_CH(NCH), .WIDTH(W), .CASCADE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.inc      = s_inc;
  assign if0.dec      = s_dec;
  assign if0.clr      = s_clr;
  assign if0.load     = s_load;
  assign if0.sat_mode = s_sat;
  assign if0.load_val = s_lv;
  assign if0.limit    = s_lim;
  assign if1.inc      = s_inc;
  assign if1.dec      = s_dec;
  assign if1.clr      = s_clr;
  assign if1.load     = s_load;
  assign if1.sat_mode = s_sat;
  assign if1.load_val = s_lv;
  assign if1.limit    = s_lim;

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int limOf(int i);
    return int'(s_lim[i*W +: W]);
  endfunction

  // Spec-level model: counts are plain integers bounded by the limit.
  function automatic void modelEval(int d);
    bit carry;
    carry = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      int lim;
      int lv;
      bit up;
      bit dn;
      c   = refCnt[d][i];
      lim = limOf(i);
      lv  = int'(s_lv[i*W +: W]);
      up  = s_inc[i] || (d == 1 && carry);
      dn  = s_dec[i];
      expOvf[d][i]  = 1'b0;
      expUnf[d][i]  = 1'b0;
      expNext[d][i] = c;
      if (s_clr[i]) expNext[d][i] = 0;
      else if (s_load[i]) expNext[d][i] = (lv < lim) ? lv : lim;
      else if (up && !dn) begin
        if (c >= lim) begin
          expOvf[d][i]  = 1'b1;
          expNext[d][i] = s_sat[i] ? lim : 0;
        end else expNext[d][i] = c + 1;
      end else if (dn && !up) begin
        if (c == 0) begin
          expUnf[d][i]  = 1'b1;
          expNext[d][i] = s_sat[i] ? 0 : lim;
        end else begin
          expNext[d][i] = c - 1;
          if (s_sat[i] && expNext[d][i] > lim) expNext[d][i] = lim;
        end
      end
      carry = expOvf[d][i];
    end
  endfunction

  function automatic void modelCommit(int d);
    for (int i = 0; i < NCH; i++) begin
      refCnt[d][i] = expNext[d][i];
      refOs[d][i]  = s_clr[i] ? 1'b0 : (refOs[d][i] | expOvf[d][i]);
      refUs[d][i]  = s_clr[i] ? 1'b0 : (refUs[d][i] | expUnf[d][i]);
    end
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        refCnt[d][i] = 0;
        refOs[d][i]  = 1'b0;
        refUs[d][i]  = 1'b0;
      end
  endfunction

  task automatic checkBank(input int d);
    logic [NCH*W-1:0] ec;
    logic [NCH-1:0]   eo, eu, em, ez, eos, eus;
    for (int i = 0; i < NCH; i++) begin
      ec[i*W +: W] = refCnt[d][i][W-1:0];
      eo[i]  = expOvf[d][i];
      eu[i]  = expUnf[d][i];
      em[i]  = (refCnt[d][i] >= limOf(i));
      ez[i]  = (refCnt[d][i] == 0);
      eos[i] = refOs[d][i];
      eus[i] = refUs[d][i];
    end
    checkOutput($sformatf("d%0d_count", d), 64'(d == 0 ? if0.count : if1.count), 64'(ec));
    checkOutput($sformatf("d%0d_ovf", d), 64'(d == 0 ? if0.ovf : if1.ovf), 64'(eo));
    checkOutput($sformatf("d%0d_unf", d), 64'(d == 0 ? if0.unf : if1.unf), 64'(eu));
    checkOutput($sformatf("d%0d_at_max", d), 64'(d == 0 ? if0.at_max : if1.at_max), 64'(em));
    checkOutput($sformatf("d%0d_at_zero", d), 64'(d == 0 ? if0.at_zero : if1.at_zero), 64'(ez));
    checkOutput($sformatf("d%0d_ovf_sticky", d), 64'(d == 0 ? if0.ovf_sticky : if1.ovf_sticky), 64'(eos));
    checkOutput($sformatf("d%0d_unf_sticky", d), 64'(d == 0 ? if0.unf_sticky : if1.unf_sticky), 64'(eus));
  endtask

  // Called at a falling edge with s_* set: check before the edge, then advance the model.
  task automatic applyStimulus();
    #1;
    modelEval(0);
    modelEval(1);
    checkBank(0);
    checkBank(1);
    @(posedge clk);
    modelCommit(0);
    modelCommit(1);
    @(negedge clk);
  endtask

  function automatic void idleInputs();
    s_inc  = '0;
    s_dec  = '0;
    s_clr  = '0;
    s_load = '0;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic applyReset();
    logic [NCH-1:0] em;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NCH; i++) em[i] = (limOf(i) == 0);
    checkOutput("rst_count0", 64'(if0.count), 64'd0);
    checkOutput("rst_count1", 64'(if1.count), 64'd0);
    checkOutput("rst_sticky0", 64'({if0.ovf_sticky, if0.unf_sticky}), 64'd0);
    checkOutput("rst_sticky1", 64'({if1.ovf_sticky, if1.unf_sticky}), 64'd0);
    checkOutput("rst_at_zero", 64'({if0.at_zero, if1.at_zero}), 64'hFF);
    checkOutput("rst_at_max", 64'(if0.at_max), 64'(em));
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wrapSeq [8];
    int satSeq  [10];
    wrapSeq = '{0, 1, 2, 3, 4, 5, 0, 1};
    satSeq  = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
    checkCount = 0;
    passCount  = 0;
    rst   = 1'b1;
    idleInputs();
    s_lv  = '0;
    s_lim = {8'd100, 8'd50, 8'd3, 8'd5};
    s_sat = 4'b0010;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    applyReset();

    // wrap on channel 0 with limit 5
    s_inc = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("wrap_count0", 64'(if0.count[7:0]), 64'(wrapSeq[k]));
      checkOutput("wrap_ovf0", 64'(if0.ovf[0]), 64'(k == 5));
      if (k == 6) checkOutput("wrap_sticky0", 64'(if0.ovf_sticky[0]), 64'd1);
      applyStimulus();
    end
    idleInputs();

    // saturate then underflow on channel 1 with limit 3
    for (int k = 0; k < 10; k++) begin
      s_inc = (k < 5) ? 4'b0010 : 4'b0000;
      s_dec = (k < 5) ? 4'b0000 : 4'b0010;
      #1;
      checkOutput("sat_count1", 64'(if0.count[15:8]), 64'(satSeq[k]));
      checkOutput("sat_unf1", 64'(if0.unf[1]), 64'(k >= 8));
      applyStimulus();
    end
    idleInputs();

    // priority on channel 2: load 4, then clr+load+inc, then clamped load
    s_load = 4'b0100; s_lv = 32'h0004_0000;
    applyStimulus();
    s_clr = 4'b0100; s_inc = 4'b0100;
    applyStimulus();
    s_clr = '0; s_inc = '0; s_lv = 32'h00C8_0000;
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("prio_count2", 64'(if0.count[23:16]), 64'd50);
    checkOutput("prio_sticky2", 64'(if0.ovf_sticky[2]), 64'd0);

    // inc and dec together on channel 3 at zero
    s_inc = 4'b1000; s_dec = 4'b1000;
    applyStimulus();
    idleInputs();

    // limit lowered under the count on channel 0, wrap then saturate
    for (int m = 0; m < 3; m++) begin
      s_lim[7:0] = 8'd20; s_load = 4'b0001; s_lv = 32'd10; s_sat[0] = (m == 2);
      applyStimulus();
      idleInputs();
      s_lim[7:0] = 8'd4;
      if (m == 0) s_inc = 4'b0001; else s_dec = 4'b0001;
      applyStimulus();
      idleInputs();
      #1;
      checkOutput("lower_count0", 64'(if0.count[7:0]), 64'(m == 0 ? 0 : (m == 1 ? 9 : 4)));
    end
    s_sat[0] = 1'b0;

    // cascade: 256 increments on channel 0 with limit 255 carry into channel 1
    s_lim = {8'd100, 8'd50, 8'd255, 8'd255};
    s_sat = '0;
    applyReset();
    s_inc = 4'b0001;
    for (int k = 0; k < 256; k++) applyStimulus();
    idleInputs();
    #1;
    checkOutput("casc_count", 64'(if1.count[15:0]), 64'h0100);
    checkOutput("casc_sticky0", 64'(if1.ovf_sticky[0]), 64'd1);
    applyReset();

    // randomized traffic, with one asynchronous reset in the middle
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) begin
        s_inc[i]  = ($urandom_range(0, 1) == 1);
        s_dec[i]  = ($urandom_range(0, 2) == 0);
        s_clr[i]  = ($urandom_range(0, 15) == 0);
        s_load[i] = ($urandom_range(0, 9) == 0);
        s_lv[i*W +: W] = 8'($urandom);
        if ($urandom_range(0, 19) == 0) s_sat[i] = ~s_sat[i];
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: s_lim[i*W +: W] = 8'd0;
            1: s_lim[i*W +: W] = 8'd255;
            2: s_lim[i*W +: W] = 8'($urandom_range(0, 7));
            default: s_lim[i*W +: W] = 8'($urandom);
          endcase
        end
      end
      applyStimulus();
      if (k == 200) applyReset();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
